// File: rtl/ball_rally_pkg.sv
// Shared types and constants for the ball rally engine: FSM states, link record, serve defaults.
package ball_rally_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN_OUT,
    ST_RUN_IN,
    ST_SEND_BALL,
    ST_SEND_LOSE,
    ST_WAIT_FLAG,
    ST_WAIT_RX,
    ST_OVER
  } state_t;

  typedef struct packed {
    logic [9:0] y;
    logic [7:0] vy;
    logic [1:0] grav;
    logic       fast;
  } link_rec_t;

  localparam logic [9:0]        SERVE_Y = 10'd220;
  localparam logic signed [7:0] VY_INIT = -8'sd3;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/ball_rally_engine_divider.sv
// Restoring unsigned divider: BASE_TICKS / divisor_i in CNT_W cycles after start_i; restart on new start.
module ball_tick_divider
  import ball_rally_pkg::*;
#(
  parameter int CNT_W      = 20,
  parameter int SPD_W      = 10,
  parameter int BASE_TICKS = 270000
) (
  input  logic             clk_25MHZ,
  input  logic             reset,
  input  logic             start_i,
  input  logic [SPD_W-1:0] divisor_i,
  output logic             done_o,
  output logic [CNT_W-1:0] quot_o
);

  localparam int CW = $clog2(CNT_W + 1);
  localparam logic [CNT_W-1:0] BASE_V = CNT_W'(BASE_TICKS);
  localparam logic [CW-1:0]    LAST_V = CW'(CNT_W - 1);

  logic [SPD_W:0]   rem_q;
  logic [SPD_W:0]   rem_sh_s;
  logic [CNT_W-1:0] quo_q;
  logic [SPD_W-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;

  assign rem_sh_s = {rem_q[SPD_W-1:0], quo_q[CNT_W-1]};

  // One quotient bit per cycle; quo_q shifts the dividend out while the quotient shifts in.
  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= '0;
      quo_q  <= BASE_V;
      dvs_q  <= divisor_i;
      cnt_q  <= '0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      if (rem_sh_s >= {1'b0, dvs_q}) begin
        rem_q <= rem_sh_s - {1'b0, dvs_q};
        quo_q <= {quo_q[CNT_W-2:0], 1'b1};
      end else begin
        rem_q <= rem_sh_s;
        quo_q <= {quo_q[CNT_W-2:0], 1'b0};
      end
      cnt_q  <= cnt_q + CW'(1);
      busy_q <= (cnt_q != LAST_V);
      done_q <= (cnt_q == LAST_V);
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done_o = done_q;
  assign quot_o = quo_q;

endmodule

// File: rtl/ball_rally_engine.sv
// Ball physics and rally FSM for one board of a two-board game.
// Optional BALL_RALLY_SCORE_EN adds saturating 4-bit self/peer score outputs.
module ball_rally_engine
  import ball_rally_pkg::*;
#(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int X_STEP      = 10,
  parameter int BALL_SZ     = 20,
  parameter int GRAV_PERIOD = 4,
  parameter int VY_MAX      = 15,
  parameter int BASE_TICKS  = 270000,
  parameter int MIN_SPD     = 2,
  parameter int SPD_W       = 10,
  parameter int CNT_W       = 20
) (
  input  logic             clk_25MHZ,
  input  logic             reset,
  input  logic             half_res_i,
  input  logic             game_start_i,
  input  logic             paddle_hit_i,
  input  logic [SPD_W-1:0] paddle_speed_i,
  output logic [9:0]       ball_x_o,
  output logic [9:0]       ball_y_o,
  output logic             moving_in_o,
  output logic             moving_out_o,
  output logic             tx_req_o,
  output logic             tx_lose_o,
  input  logic             tx_ack_i,
  output logic [9:0]       tx_y_o,
  output logic [7:0]       tx_vy_o,
  output logic [1:0]       tx_grav_o,
  output logic             tx_fast_o,
  input  logic             rx_valid_i,
  input  logic [9:0]       rx_y_i,
  input  logic [7:0]       rx_vy_i,
  input  logic [1:0]       rx_grav_i,
  input  logic             rx_fast_i,
  input  logic             rx_win_i,
  output logic             rx_busy_o,
  output logic             idle_o,
  output logic             game_over_o,
  output logic             is_win_o,
  output logic             is_lose_o
`ifdef BALL_RALLY_SCORE_EN
  ,
  output logic [3:0]       score_self_o,
  output logic [3:0]       score_peer_o
`endif
);

  localparam logic [CNT_W-1:0]  BASE_V    = CNT_W'(BASE_TICKS);
  localparam logic [CNT_W-1:0]  HALF_V    = CNT_W'(BASE_TICKS / 2);
  localparam logic [CNT_W-1:0]  ONE_T     = CNT_W'(1);
  localparam logic [9:0]        XSTEP_V   = 10'(X_STEP);
  localparam logic [1:0]        GRAV_LAST = 2'(GRAV_PERIOD - 1);
  localparam logic signed [7:0] VY_MAX_V  = 8'(VY_MAX);
  localparam logic [SPD_W-1:0]  MIN_SPD_V = SPD_W'(MIN_SPD);

  state_t state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic signed [7:0] vy_q, vy_d;
  logic [1:0] grav_q, grav_d;
  logic [CNT_W-1:0] ticks_q, ticks_d, cnt_q, cnt_d;
  link_rec_t tx_q, tx_d;
  logic tx_req_q, tx_req_d, tx_lose_q, tx_lose_d, is_win_q, is_win_d, div_pend_q, div_pend_d;
  logic idle_q, game_over_q, is_lose_q, rx_busy_q, moving_in_q, moving_out_q;

  logic [9:0] xr_s, yr_s, y_n_s;
  logic [10:0] x_out_s;
  logic signed [10:0] y_sum_s;
  logic signed [7:0] vy_g_s, vy_n_s;
  logic [1:0] grav_n_s;
  logic step_s, div_start_s, div_done_s;
  logic [CNT_W-1:0] div_quot_s;
  logic [SPD_W-1:0] spd_clamp_s;

  assign xr_s        = half_res_i ? 10'(H_RES / 2 - BALL_SZ) : 10'(H_RES - BALL_SZ);
  assign yr_s        = half_res_i ? 10'(V_RES / 2 - 1) : 10'(V_RES - 1);
  assign step_s      = (cnt_q >= ticks_q - ONE_T);
  assign x_out_s     = {1'b0, x_q} + {1'b0, XSTEP_V};
  assign spd_clamp_s = (paddle_speed_i < MIN_SPD_V) ? MIN_SPD_V : paddle_speed_i;

  ball_tick_divider #(.CNT_W(CNT_W), .SPD_W(SPD_W), .BASE_TICKS(BASE_TICKS)) u_div (
    .clk_25MHZ(clk_25MHZ),
    .reset    (reset),
    .start_i  (div_start_s),
    .divisor_i(spd_clamp_s),
    .done_o   (div_done_s),
    .quot_o   (div_quot_s)
  );

  // Vertical physics for one step: gravity phase, 11-bit signed position, clamp and bounce.
  always_comb begin
    grav_n_s = grav_q + 2'd1;
    if (grav_q == GRAV_LAST) begin
      grav_n_s = 2'd0;
      if (vy_q >= VY_MAX_V) vy_g_s = VY_MAX_V;
      else                  vy_g_s = vy_q + 8'sd1;
    end else begin
      vy_g_s = vy_q;
    end
    y_sum_s = $signed({1'b0, y_q}) + $signed({{3{vy_q[7]}}, vy_q});
    if (y_sum_s >= $signed({1'b0, yr_s})) begin
      y_n_s  = yr_s;
      vy_n_s = -vy_g_s;
    end else if (y_sum_s <= 11'sd0) begin
      y_n_s  = 10'd0;
      vy_n_s = -vy_g_s;
    end else begin
      y_n_s  = y_sum_s[9:0];
      vy_n_s = vy_g_s;
    end
  end

  // Rally state transitions and datapath next-state.
  always_comb begin
    state_d = state_q;  x_d = x_q;  y_d = y_q;  vy_d = vy_q;  grav_d = grav_q;
    ticks_d = ticks_q;  cnt_d = cnt_q;  tx_d = tx_q;  tx_req_d = tx_req_q;  tx_lose_d = tx_lose_q;
    is_win_d = is_win_q;  div_pend_d = div_pend_q;  div_start_s = 1'b0;
    if (div_done_s && div_pend_q) begin
      ticks_d    = (div_quot_s == '0) ? ONE_T : div_quot_s;  // too-fast paddles step every clock
      div_pend_d = 1'b0;
    end else begin
      ticks_d = ticks_q;
    end
    case (state_q)
      ST_IDLE, ST_WAIT_FLAG: begin
        if (game_start_i && state_q == ST_IDLE) begin
          state_d = ST_RUN_OUT;  x_d = 10'd0;  y_d = SERVE_Y;  vy_d = VY_INIT;  grav_d = 2'd0;
          ticks_d = BASE_V;  cnt_d = '0;  is_win_d = 1'b0;  div_pend_d = 1'b0;
        end else if (game_start_i) begin
          state_d = ST_IDLE;
        end else if (rx_valid_i) begin
          state_d = ST_WAIT_RX;  x_d = xr_s;  y_d = rx_y_i;  vy_d = $signed(rx_vy_i);
          grav_d = rx_grav_i;  ticks_d = rx_fast_i ? BASE_V : HALF_V;  cnt_d = '0;  div_pend_d = 1'b0;
          if (state_q == ST_WAIT_FLAG) is_win_d = rx_win_i;
          else                         is_win_d = is_win_q;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN_OUT, ST_RUN_IN: begin
        if (paddle_hit_i) begin
          div_start_s = 1'b1;
          div_pend_d  = 1'b1;
        end else begin
          div_start_s = 1'b0;
        end
        if (paddle_hit_i && state_q == ST_RUN_IN) begin
          state_d = ST_RUN_OUT;
          cnt_d   = '0;
        end else if (step_s) begin
          cnt_d = '0;  y_d = y_n_s;  vy_d = vy_n_s;  grav_d = grav_n_s;
          if (state_q == ST_RUN_OUT) begin
            x_d = x_out_s[9:0];
            if (x_out_s >= {1'b0, xr_s}) begin
              state_d  = ST_SEND_BALL;  tx_req_d = 1'b1;  tx_lose_d = 1'b0;
              tx_d     = '{y: y_n_s, vy: vy_n_s, grav: grav_n_s, fast: (ticks_q == BASE_V)};
            end else begin
              state_d = ST_RUN_OUT;
            end
          end else if (x_q < XSTEP_V) begin
            x_d = 10'd0;  state_d = ST_SEND_LOSE;  tx_req_d = 1'b1;  tx_lose_d = 1'b1;
          end else begin
            x_d = x_q - XSTEP_V;
          end
        end else begin
          cnt_d = cnt_q + ONE_T;
        end
      end
      ST_SEND_BALL, ST_SEND_LOSE: begin
        if (game_start_i) begin
          state_d = ST_IDLE;  tx_req_d = 1'b0;
        end else if (tx_ack_i) begin
          state_d  = (state_q == ST_SEND_BALL) ? ST_WAIT_FLAG : ST_OVER;
          tx_req_d = 1'b0;
        end else begin
          tx_req_d = 1'b1;
        end
      end
      ST_WAIT_RX: begin
        if (game_start_i)     state_d = ST_IDLE;
        else if (!rx_valid_i) state_d = is_win_q ? ST_IDLE : ST_RUN_IN;
        else                  state_d = ST_WAIT_RX;
      end
      ST_OVER: begin
        if (rx_valid_i || game_start_i) state_d = ST_IDLE;
        else                            state_d = ST_OVER;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and status flags; flags decode the next state so they align with it.
  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;  x_q <= 10'd0;  y_q <= SERVE_Y;  vy_q <= VY_INIT;  grav_q <= 2'd0;
      ticks_q <= BASE_V;  cnt_q <= '0;  tx_q <= '0;  tx_req_q <= 1'b0;  tx_lose_q <= 1'b0;
      is_win_q <= 1'b0;  div_pend_q <= 1'b0;  idle_q <= 1'b1;  game_over_q <= 1'b0;
      is_lose_q <= 1'b0;  rx_busy_q <= 1'b0;  moving_in_q <= 1'b0;  moving_out_q <= 1'b0;
    end else begin
      state_q <= state_d;  x_q <= x_d;  y_q <= y_d;  vy_q <= vy_d;  grav_q <= grav_d;
      ticks_q <= ticks_d;  cnt_q <= cnt_d;  tx_q <= tx_d;  tx_req_q <= tx_req_d;
      tx_lose_q <= tx_lose_d;  is_win_q <= is_win_d;  div_pend_q <= div_pend_d;
      idle_q       <= (state_d == ST_IDLE);
      game_over_q  <= (state_d == ST_SEND_LOSE) || (state_d == ST_OVER);
      is_lose_q    <= (state_d == ST_SEND_LOSE) || (state_d == ST_OVER);
      rx_busy_q    <= (state_d == ST_WAIT_RX);
      moving_in_q  <= (state_d == ST_RUN_IN);
      moving_out_q <= (state_d == ST_RUN_OUT);
    end
  end

  assign ball_x_o     = x_q;
  assign ball_y_o     = y_q;
  assign moving_in_o  = moving_in_q;
  assign moving_out_o = moving_out_q;
  assign tx_req_o     = tx_req_q;
  assign tx_lose_o    = tx_lose_q;
  assign tx_y_o       = tx_q.y;
  assign tx_vy_o      = tx_q.vy;
  assign tx_grav_o    = tx_q.grav;
  assign tx_fast_o    = tx_q.fast;
  assign rx_busy_o    = rx_busy_q;
  assign idle_o       = idle_q;
  assign game_over_o  = game_over_q;
  assign is_win_o     = is_win_q;
  assign is_lose_o    = is_lose_q;

`ifdef BALL_RALLY_SCORE_EN
  logic [3:0] score_self_q, score_peer_q;

  // Peer scores when we start a loss notice; we score when the peer's flag says we won.
  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      score_self_q <= 4'd0;
      score_peer_q <= 4'd0;
    end else if (state_q == ST_IDLE && game_start_i) begin
      score_self_q <= 4'd0;
      score_peer_q <= 4'd0;
    end else begin
      if (state_q != ST_SEND_LOSE && state_d == ST_SEND_LOSE) score_peer_q <= sat_inc4(score_peer_q);
      else                                                     score_peer_q <= score_peer_q;
      if (state_q == ST_WAIT_FLAG && state_d == ST_WAIT_RX && rx_win_i) score_self_q <= sat_inc4(score_self_q);
      else                                                              score_self_q <= score_self_q;
    end
  end

  assign score_self_o = score_self_q;
  assign score_peer_o = score_peer_q;
`endif

endmodule

// File: tb/tb_ball_rally_engine.sv
// Directed bench for ball_rally_engine with BASE_TICKS=4 and an 8-cycle divider.
module tb_ball_rally_engine;

  logic clk_25MHZ = 1'b0;
  logic reset = 1'b1;
  logic half_res = 1'b0, game_start = 1'b0, paddle_hit = 1'b0, tx_ack = 1'b0;
  logic [9:0] paddle_speed = 10'd0;
  logic rx_valid = 1'b0, rx_fast = 1'b0, rx_win = 1'b0;
  logic [9:0] rx_y = 10'd0;
  logic [7:0] rx_vy = 8'd0;
  logic [1:0] rx_grav = 2'd0;
  logic [9:0] ball_x, ball_y, tx_y;
  logic [7:0] tx_vy;
  logic [1:0] tx_grav;
  logic moving_in, moving_out, tx_req, tx_lose, tx_fast, rx_busy, idle, game_over, is_win, is_lose;
  int n_cmp = 0;
  int n_bad = 0;

  always #20 clk_25MHZ = ~clk_25MHZ;

  ball_rally_engine #(.BASE_TICKS(4), .CNT_W(8)) dut (
    .clk_25MHZ(clk_25MHZ), .reset(reset), .half_res_i(half_res), .game_start_i(game_start),
    .paddle_hit_i(paddle_hit), .paddle_speed_i(paddle_speed), .ball_x_o(ball_x), .ball_y_o(ball_y),
    .moving_in_o(moving_in), .moving_out_o(moving_out), .tx_req_o(tx_req), .tx_lose_o(tx_lose),
    .tx_ack_i(tx_ack), .tx_y_o(tx_y), .tx_vy_o(tx_vy), .tx_grav_o(tx_grav), .tx_fast_o(tx_fast),
    .rx_valid_i(rx_valid), .rx_y_i(rx_y), .rx_vy_i(rx_vy), .rx_grav_i(rx_grav), .rx_fast_i(rx_fast),
    .rx_win_i(rx_win), .rx_busy_o(rx_busy), .idle_o(idle), .game_over_o(game_over),
    .is_win_o(is_win), .is_lose_o(is_lose)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_25MHZ);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; game_start = 1'b0; paddle_hit = 1'b0; tx_ack = 1'b0; rx_valid = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(1);
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle: got %0b want 1", idle); end
    n_cmp++; if (ball_x !== 10'd0) begin n_bad++; $display("FAIL reset_x: got %0d want 0", ball_x); end
    n_cmp++; if (ball_y !== 10'd220) begin n_bad++; $display("FAIL reset_y: got %0d want 220", ball_y); end
    n_cmp++; if ({tx_req, game_over, moving_out, is_win} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {tx_req, game_over, moving_out, is_win}); end
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_serve();
    do_reset();
    half_res = 1'b0;
    game_start = 1'b1; cyc(1); game_start = 1'b0;
    n_cmp++; if ({moving_out, idle} !== 2'b10) begin n_bad++; $display("FAIL serve_state: got %b want 10", {moving_out, idle}); end
    cyc(3);
    n_cmp++; if (ball_x !== 10'd0) begin n_bad++; $display("FAIL serve_x_wait: got %0d want 0", ball_x); end
    cyc(1);
    n_cmp++; if (ball_x !== 10'd10 || ball_y !== 10'd217) begin n_bad++; $display("FAIL serve_step1: got x=%0d y=%0d want x=10 y=217", ball_x, ball_y); end
    cyc(12);
    n_cmp++; if (ball_x !== 10'd40 || ball_y !== 10'd208) begin n_bad++; $display("FAIL serve_step4: got x=%0d y=%0d want x=40 y=208", ball_x, ball_y); end
    cyc(4);
    n_cmp++; if (ball_x !== 10'd50 || ball_y !== 10'd206) begin n_bad++; $display("FAIL serve_gravity: got x=%0d y=%0d want x=50 y=206", ball_x, ball_y); end
  endtask

  task automatic test_half_res_send();
    do_reset();
    half_res = 1'b1;
    game_start = 1'b1; cyc(1); game_start = 1'b0;
    cyc(119);
    n_cmp++; if (ball_x !== 10'd290 || tx_req !== 1'b0 || moving_out !== 1'b1) begin n_bad++; $display("FAIL half_pre_send: got x=%0d req=%0b out=%0b want 290 0 1", ball_x, tx_req, moving_out); end
    cyc(1);
    n_cmp++; if (ball_x !== 10'd300 || tx_req !== 1'b1 || tx_lose !== 1'b0 || moving_out !== 1'b0) begin n_bad++; $display("FAIL half_send: got x=%0d req=%0b lose=%0b out=%0b want 300 1 0 0", ball_x, tx_req, tx_lose, moving_out); end
    n_cmp++; if (tx_y !== 10'd228 || tx_vy !== 8'd4 || tx_grav !== 2'd2 || tx_fast !== 1'b1) begin n_bad++; $display("FAIL half_tx_rec: got y=%0d vy=%0d g=%0d f=%0b want 228 4 2 1", tx_y, tx_vy, tx_grav, tx_fast); end
    cyc(3);
    n_cmp++; if (tx_req !== 1'b1 || tx_y !== 10'd228) begin n_bad++; $display("FAIL half_req_hold: got req=%0b y=%0d want 1 228", tx_req, tx_y); end
    tx_ack = 1'b1; cyc(1); tx_ack = 1'b0;
    n_cmp++; if ({tx_req, idle, rx_busy, moving_in} !== 4'b0000) begin n_bad++; $display("FAIL half_ack: got %b want 0000", {tx_req, idle, rx_busy, moving_in}); end
    rx_valid = 1'b1; rx_win = 1'b1; rx_y = 10'd50; rx_vy = 8'd0; rx_grav = 2'd0; rx_fast = 1'b1;
    cyc(1);
    n_cmp++; if (rx_busy !== 1'b1 || is_win !== 1'b1) begin n_bad++; $display("FAIL flag_rx: got busy=%0b win=%0b want 1 1", rx_busy, is_win); end
    rx_valid = 1'b0; cyc(1);
    n_cmp++; if ({idle, rx_busy, is_win, moving_in} !== 4'b1010) begin n_bad++; $display("FAIL flag_win_idle: got %b want 1010", {idle, rx_busy, is_win, moving_in}); end
    rx_win = 1'b0;
  endtask

  task automatic test_rx_in_lose();
    do_reset();
    half_res = 1'b0;
    rx_valid = 1'b1; rx_y = 10'd100; rx_vy = 8'hFE; rx_grav = 2'd0; rx_fast = 1'b0; rx_win = 1'b0;
    cyc(1);
    n_cmp++; if (rx_busy !== 1'b1 || ball_x !== 10'd620 || ball_y !== 10'd100 || idle !== 1'b0) begin n_bad++; $display("FAIL rx_load: got busy=%0b x=%0d y=%0d idle=%0b want 1 620 100 0", rx_busy, ball_x, ball_y, idle); end
    cyc(2);
    rx_valid = 1'b0; cyc(1);
    n_cmp++; if (moving_in !== 1'b1 || rx_busy !== 1'b0) begin n_bad++; $display("FAIL rx_run_in: got in=%0b busy=%0b want 1 0", moving_in, rx_busy); end
    cyc(1);
    n_cmp++; if (ball_x !== 10'd620) begin n_bad++; $display("FAIL rx_half_wait: got %0d want 620", ball_x); end
    cyc(1);
    n_cmp++; if (ball_x !== 10'd610 || ball_y !== 10'd98) begin n_bad++; $display("FAIL rx_half_step: got x=%0d y=%0d want 610 98", ball_x, ball_y); end
    cyc(123);
    n_cmp++; if (ball_x !== 10'd0 || tx_req !== 1'b0 || moving_in !== 1'b1) begin n_bad++; $display("FAIL lose_pre: got x=%0d req=%0b in=%0b want 0 0 1", ball_x, tx_req, moving_in); end
    cyc(1);
    n_cmp++; if ({tx_req, tx_lose, game_over, is_lose, moving_in} !== 5'b11110 || ball_x !== 10'd0) begin n_bad++; $display("FAIL lose_send: got %b x=%0d want 11110 x=0", {tx_req, tx_lose, game_over, is_lose, moving_in}, ball_x); end
    tx_ack = 1'b1; cyc(1); tx_ack = 1'b0;
    n_cmp++; if ({tx_req, game_over, is_lose} !== 3'b011) begin n_bad++; $display("FAIL lose_ack: got %b want 011", {tx_req, game_over, is_lose}); end
    cyc(2);
    n_cmp++; if (game_over !== 1'b1 || idle !== 1'b0) begin n_bad++; $display("FAIL over_hold: got over=%0b idle=%0b want 1 0", game_over, idle); end
    game_start = 1'b1; cyc(1); game_start = 1'b0;
    n_cmp++; if ({idle, game_over, is_lose, moving_out} !== 4'b1000) begin n_bad++; $display("FAIL over_restart: got %b want 1000", {idle, game_over, is_lose, moving_out}); end
  endtask

  task automatic test_paddle_speed();
    do_reset();
    half_res = 1'b0;
    game_start = 1'b1; cyc(1); game_start = 1'b0;
    paddle_speed = 10'd1; paddle_hit = 1'b1; cyc(1); paddle_hit = 1'b0;
    cyc(8);
    n_cmp++; if (ball_x !== 10'd20) begin n_bad++; $display("FAIL spd1_old_ticks: got %0d want 20", ball_x); end
    cyc(1);
    n_cmp++; if (ball_x !== 10'd20) begin n_bad++; $display("FAIL spd1_switch: got %0d want 20", ball_x); end
    cyc(1);
    n_cmp++; if (ball_x !== 10'd30) begin n_bad++; $display("FAIL spd1_step: got %0d want 30", ball_x); end
    cyc(2);
    n_cmp++; if (ball_x !== 10'd40) begin n_bad++; $display("FAIL spd1_period2: got %0d want 40", ball_x); end
    // 4/9 truncates to zero, which the engine runs as one step per clock
    paddle_speed = 10'd9; paddle_hit = 1'b1; cyc(1); paddle_hit = 1'b0;
    cyc(8);
    n_cmp++; if (ball_x !== 10'd80) begin n_bad++; $display("FAIL spd9_old_ticks: got %0d want 80", ball_x); end
    cyc(2);
    n_cmp++; if (ball_x !== 10'd100) begin n_bad++; $display("FAIL spd9_switch: got %0d want 100", ball_x); end
    cyc(1);
    n_cmp++; if (ball_x !== 10'd110 || moving_out !== 1'b1) begin n_bad++; $display("FAIL spd9_period1: got x=%0d out=%0b want 110 1", ball_x, moving_out); end
  endtask

  task automatic test_bounce();
    do_reset();
    rx_valid = 1'b1; rx_y = 10'd3; rx_vy = 8'hFB; rx_grav = 2'd0; rx_fast = 1'b1; rx_win = 1'b0;
    cyc(1); rx_valid = 1'b0; cyc(1);
    cyc(3);
    n_cmp++; if (ball_y !== 10'd3) begin n_bad++; $display("FAIL bounce_wait: got %0d want 3", ball_y); end
    cyc(1);
    n_cmp++; if (ball_y !== 10'd0 || ball_x !== 10'd610) begin n_bad++; $display("FAIL bounce_clamp: got y=%0d x=%0d want 0 610", ball_y, ball_x); end
    cyc(4);
    n_cmp++; if (ball_y !== 10'd5 || ball_x !== 10'd600) begin n_bad++; $display("FAIL bounce_vy_pos: got y=%0d x=%0d want 5 600", ball_y, ball_x); end
  endtask

  task automatic test_hit_at_edge();
    do_reset();
    rx_valid = 1'b1; rx_y = 10'd200; rx_vy = 8'd0; rx_grav = 2'd0; rx_fast = 1'b0; rx_win = 1'b0;
    cyc(1); rx_valid = 1'b0; cyc(1);
    cyc(125);
    n_cmp++; if (ball_x !== 10'd0 || moving_in !== 1'b1) begin n_bad++; $display("FAIL edge_pre: got x=%0d in=%0b want 0 1", ball_x, moving_in); end
    paddle_speed = 10'd2; paddle_hit = 1'b1; cyc(1); paddle_hit = 1'b0;
    n_cmp++; if ({moving_out, tx_req, game_over} !== 3'b100 || ball_x !== 10'd0) begin n_bad++; $display("FAIL edge_hit_wins: got %b x=%0d want 100 x=0", {moving_out, tx_req, game_over}, ball_x); end
    cyc(2);
    n_cmp++; if (ball_x !== 10'd10) begin n_bad++; $display("FAIL edge_out_step: got %0d want 10", ball_x); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_serve();
    test_half_res_send();
    test_rx_in_lose();
    test_paddle_speed();
    test_bounce();
    test_hit_at_edge();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
